// File: rtl/branch_resolver.sv
// branch_resolver: ID-stage branch/jump resolution unit.
// Computes the redirect target and detects operand hazards that make the
// comparator result stale. It stalls until the operands are valid, then
// issues a one-cycle registered PC redirect with IF/ID and ID/EX flushes.
// It also keeps wrap-around branch statistics counters.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   branchEqualInput        ID instruction is BEQ
//   branchNotEqualInput     ID instruction is BNE
//   jumpInput               ID instruction is J (priority over branches)
//   zeroTestInput           comparator flag, 1 when Rs != Rt
//   pcPlus4Input            PC+4 of the ID instruction
//   immediateInput          sign-extended branch offset (words)
//   jumpIndexInput          J-format index field
//   rsInput, rtInput        ID source registers
//   exRegWriteInput, exMemReadInput, exRdInput   EX-stage writer info
//   memMemReadInput, memRdInput                  MEM-stage load info
//   stallOutput             hold PC and IF/ID, bubble into ID/EX
//   pcSrcOutput             PC loads branchTargetOutput this cycle
//   branchTargetOutput      redirect address (holds outside redirect)
//   flushIfIdOutput         zero IF/ID at the next edge
//   flushIdExOutput         squash ID instruction into ID/EX
//   branchCountOutput       resolved conditional branches
//   takenCountOutput        taken branches plus jumps
module branch_resolver #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   branchEqualInput,
    input  logic                   branchNotEqualInput,
    input  logic                   jumpInput,
    input  logic                   zeroTestInput,
    input  logic [31:0]            pcPlus4Input,
    input  logic [31:0]            immediateInput,
    input  logic [25:0]            jumpIndexInput,
    input  logic [4:0]             rsInput,
    input  logic [4:0]             rtInput,
    input  logic                   exRegWriteInput,
    input  logic                   exMemReadInput,
    input  logic [4:0]             exRdInput,
    input  logic                   memMemReadInput,
    input  logic [4:0]             memRdInput,
    output logic                   stallOutput,
    output logic                   pcSrcOutput,
    output logic [31:0]            branchTargetOutput,
    output logic                   flushIfIdOutput,
    output logic                   flushIdExOutput,
    output logic [COUNT_WIDTH-1:0] branchCountOutput,
    output logic [COUNT_WIDTH-1:0] takenCountOutput
);

    localparam int unsigned STALL_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t                   state, state_next;
    logic [STALL_CNT_W-1:0]   stall_cnt, stall_cnt_next;
    logic [31:0]              target_q;
    logic [COUNT_WIDTH-1:0]   branch_cnt_q, taken_cnt_q;

    logic                     is_branch;
    logic                     branch_cond;
    logic                     ex_match, mem_match;
    logic [STALL_CNT_W-1:0]   hazard_n;
    logic [31:0]              target_c;
    logic                     resolve;
    logic                     taken;
    logic                     stall;

    // Decode-level classification; a jump overrides any branch bit.
    assign is_branch   = (branchEqualInput | branchNotEqualInput) & ~jumpInput;
    assign branch_cond = (branchEqualInput & ~zeroTestInput) |
                         (branchNotEqualInput & zeroTestInput);

    // Register 0 is hardwired, so it never creates a dependency.
    assign ex_match  = (exRdInput != 5'd0) &&
                       ((rsInput == exRdInput) || (rtInput == exRdInput));
    assign mem_match = (memRdInput != 5'd0) &&
                       ((rsInput == memRdInput) || (rtInput == memRdInput));

    // Cycles until the comparator sees valid operands.
    always_comb begin
        hazard_n = STALL_CNT_W'(0);
        if (exMemReadInput && ex_match)
            hazard_n = STALL_CNT_W'(2);
        else if (exRegWriteInput && ex_match)
            hazard_n = STALL_CNT_W'(1);
        else if (memMemReadInput && mem_match)
            hazard_n = STALL_CNT_W'(1);
    end

    assign target_c = jumpInput ? {pcPlus4Input[31:28], jumpIndexInput, 2'b00}
                                : pcPlus4Input + (immediateInput << 2);

    // Next-state and control decode.
    always_comb begin
        state_next     = state;
        stall_cnt_next = stall_cnt;
        stall          = 1'b0;
        resolve        = 1'b0;
        taken          = 1'b0;
        case (state)
            IDLE: begin
                if (is_branch && (hazard_n != STALL_CNT_W'(0))) begin
                    stall          = 1'b1;
                    stall_cnt_next = hazard_n - STALL_CNT_W'(1);
                    if (hazard_n > STALL_CNT_W'(1))
                        state_next = STALL;
                end else if (is_branch || jumpInput) begin
                    resolve = 1'b1;
                    taken   = jumpInput | branch_cond;
                    if (taken)
                        state_next = REDIRECT;
                end
            end
            STALL: begin
                // Hazard inputs are not re-sampled; the count alone decides.
                stall          = 1'b1;
                stall_cnt_next = stall_cnt - STALL_CNT_W'(1);
                if (stall_cnt <= STALL_CNT_W'(1))
                    state_next = IDLE;
            end
            REDIRECT: begin
                // The ID instruction here is wrong-path and is ignored.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, target and statistics registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            stall_cnt    <= STALL_CNT_W'(0);
            target_q     <= 32'd0;
            branch_cnt_q <= COUNT_WIDTH'(0);
            taken_cnt_q  <= COUNT_WIDTH'(0);
        end else begin
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
            if (resolve && taken)
                target_q <= target_c;
            if (resolve && is_branch)
                branch_cnt_q <= branch_cnt_q + COUNT_WIDTH'(1);
            if (resolve && taken)
                taken_cnt_q <= taken_cnt_q + COUNT_WIDTH'(1);
        end
    end

    assign stallOutput        = stall;
    assign pcSrcOutput        = (state == REDIRECT);
    assign flushIfIdOutput    = (state == REDIRECT);
    assign flushIdExOutput    = (state == REDIRECT);
    assign branchTargetOutput = target_q;
    assign branchCountOutput  = branch_cnt_q;
    assign takenCountOutput   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: self-checking bench for branch_resolver using directed
// scenarios plus random instructions against a transaction-level model.
module tb_branch_resolver;

    localparam int unsigned CW = 8;

    typedef struct {
        logic        beq, bne, j, zero;
        logic [31:0] pc, imm;
        logic [25:0] idx;
        logic [4:0]  rs, rt, exrd, memrd;
        logic        exrw, exmr, memmr;
    } instr_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          branchEqualInput, branchNotEqualInput, jumpInput, zeroTestInput;
    logic [31:0]   pcPlus4Input, immediateInput;
    logic [25:0]   jumpIndexInput;
    logic [4:0]    rsInput, rtInput, exRdInput, memRdInput;
    logic          exRegWriteInput, exMemReadInput, memMemReadInput;
    logic          stallOutput, pcSrcOutput, flushIfIdOutput, flushIdExOutput;
    logic [31:0]   branchTargetOutput;
    logic [CW-1:0] branchCountOutput, takenCountOutput;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int          exp_bc = 0;
    int          exp_tc = 0;
    logic [31:0] exp_tgt = 32'd0;

    always #5 clock = ~clock;

    branch_resolver #(.COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .branchEqualInput(branchEqualInput), .branchNotEqualInput(branchNotEqualInput),
        .jumpInput(jumpInput), .zeroTestInput(zeroTestInput),
        .pcPlus4Input(pcPlus4Input), .immediateInput(immediateInput),
        .jumpIndexInput(jumpIndexInput), .rsInput(rsInput), .rtInput(rtInput),
        .exRegWriteInput(exRegWriteInput), .exMemReadInput(exMemReadInput),
        .exRdInput(exRdInput), .memMemReadInput(memMemReadInput), .memRdInput(memRdInput),
        .stallOutput(stallOutput), .pcSrcOutput(pcSrcOutput),
        .branchTargetOutput(branchTargetOutput),
        .flushIfIdOutput(flushIfIdOutput), .flushIdExOutput(flushIdExOutput),
        .branchCountOutput(branchCountOutput), .takenCountOutput(takenCountOutput)
    );

    task automatic clear_inputs();
        branchEqualInput = 0; branchNotEqualInput = 0; jumpInput = 0; zeroTestInput = 0;
        pcPlus4Input = 0; immediateInput = 0; jumpIndexInput = 0;
        rsInput = 0; rtInput = 0; exRdInput = 0; memRdInput = 0;
        exRegWriteInput = 0; exMemReadInput = 0; memMemReadInput = 0;
    endtask

    task automatic apply(input instr_t t);
        branchEqualInput = t.beq; branchNotEqualInput = t.bne; jumpInput = t.j;
        zeroTestInput = t.zero; pcPlus4Input = t.pc; immediateInput = t.imm;
        jumpIndexInput = t.idx; rsInput = t.rs; rtInput = t.rt;
        exRegWriteInput = t.exrw; exMemReadInput = t.exmr; exRdInput = t.exrd;
        memMemReadInput = t.memmr; memRdInput = t.memrd;
    endtask

    function automatic bit uses(input instr_t t, input logic [4:0] rd);
        return (rd != 0) && (t.rs == rd || t.rt == rd);
    endfunction

    // Stall cycles implied by the forwarding rules for this instruction.
    function automatic int stalls_for(input instr_t t);
        if (t.j || !(t.beq || t.bne)) return 0;
        if (t.exmr && uses(t, t.exrd)) return 2;
        if (t.exrw && uses(t, t.exrd)) return 1;
        if (t.memmr && uses(t, t.memrd)) return 1;
        return 0;
    endfunction

    function automatic instr_t blank();
        instr_t t;
        t = '{default: '0};
        return t;
    endfunction

    // Issue one ID instruction and follow it through stall, resolution and redirect.
    task automatic run_instr(input instr_t t, input string name);
        int   n;
        bit   is_br, tk;
        logic [31:0] tgt;
        is_br = !t.j && (t.beq || t.bne);
        tk    = t.j || (is_br && ((t.beq && !t.zero) || (t.bne && t.zero)));
        tgt   = t.j ? {t.pc[31:28], t.idx, 2'b00} : t.pc + t.imm * 4;
        n     = stalls_for(t);
        @(posedge clock); #1;
        apply(t);
        for (int k = 0; k < n; k++) begin
            #1;
            total++;
            if (stallOutput !== 1'b1 || pcSrcOutput !== 1'b0)
                $display("FAIL %s stall cycle %0d: stall=%b pcSrc=%b, want stall=1 pcSrc=0",
                         name, k, stallOutput, pcSrcOutput);
            else passed++;
            @(posedge clock); #1;
        end
        // Operands become valid once the producer has moved on.
        exRegWriteInput = 0; exMemReadInput = 0; memMemReadInput = 0;
        #1;
        total++;
        if (stallOutput !== 1'b0 || pcSrcOutput !== 1'b0)
            $display("FAIL %s resolve cycle: stall=%b pcSrc=%b, want 0 0",
                     name, stallOutput, pcSrcOutput);
        else passed++;
        @(posedge clock); #1;
        clear_inputs();
        if (is_br) exp_bc = (exp_bc + 1) % (1 << CW);
        if (tk) begin
            exp_tc  = (exp_tc + 1) % (1 << CW);
            exp_tgt = tgt;
        end
        #1;
        total++;
        if (pcSrcOutput !== tk || flushIfIdOutput !== tk || flushIdExOutput !== tk ||
            branchTargetOutput !== exp_tgt)
            $display("FAIL %s redirect: pcSrc=%b flush=%b%b target=%h, want %b %b%b %h",
                     name, pcSrcOutput, flushIfIdOutput, flushIdExOutput, branchTargetOutput,
                     tk, tk, tk, exp_tgt);
        else passed++;
        total++;
        if (branchCountOutput !== CW'(exp_bc) || takenCountOutput !== CW'(exp_tc))
            $display("FAIL %s counters: branch=%0d taken=%0d, want %0d %0d",
                     name, branchCountOutput, takenCountOutput, exp_bc, exp_tc);
        else passed++;
        if (tk) begin
            @(posedge clock); #2;
            total++;
            if (pcSrcOutput !== 1'b0 || stallOutput !== 1'b0)
                $display("FAIL %s post-redirect: pcSrc=%b stall=%b, want 0 0",
                         name, pcSrcOutput, stallOutput);
            else passed++;
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({stallOutput, pcSrcOutput, flushIfIdOutput, flushIdExOutput,
             branchTargetOutput, branchCountOutput, takenCountOutput} !== '0)
            $display("FAIL %s: stall=%b pcSrc=%b flush=%b%b target=%h bc=%0d tc=%0d, want all 0",
                     name, stallOutput, pcSrcOutput, flushIfIdOutput, flushIdExOutput,
                     branchTargetOutput, branchCountOutput, takenCountOutput);
        else passed++;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1; clear_inputs();
        @(posedge clock); #1;
        reset = 0;
        exp_bc = 0; exp_tc = 0; exp_tgt = 0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 0;
        #1 check_all_zero("reset_values");
    endtask

    task automatic test_taken_beq();
        instr_t t = blank();
        t.beq = 1; t.zero = 0; t.pc = 32'h0040_0010; t.imm = 32'h3;
        run_instr(t, "taken_beq");
        total++;
        if (branchTargetOutput !== 32'h0040_001C || branchCountOutput !== CW'(1) ||
            takenCountOutput !== CW'(1))
            $display("FAIL taken_beq_const: target=%h bc=%0d tc=%0d, want 0040001c 1 1",
                     branchTargetOutput, branchCountOutput, takenCountOutput);
        else passed++;
    endtask

    task automatic test_not_taken_bne();
        instr_t t = blank();
        t.bne = 1; t.zero = 0; t.pc = 32'h1234_5670; t.imm = 32'h40;
        run_instr(t, "not_taken_bne");
        total++;
        if (branchTargetOutput !== 32'h0040_001C || takenCountOutput !== CW'(1) ||
            branchCountOutput !== CW'(2))
            $display("FAIL not_taken_hold: target=%h bc=%0d tc=%0d, want 0040001c 2 1",
                     branchTargetOutput, branchCountOutput, takenCountOutput);
        else passed++;
    endtask

    task automatic test_negative_offset();
        instr_t t = blank();
        t.bne = 1; t.zero = 1; t.pc = 32'h0040_0010; t.imm = 32'hFFFF_FFFE;
        run_instr(t, "neg_offset");
        total++;
        if (branchTargetOutput !== 32'h0040_0008)
            $display("FAIL neg_offset_const: target=%h, want 00400008", branchTargetOutput);
        else passed++;
    endtask

    task automatic test_load_use();
        instr_t t = blank();
        t.beq = 1; t.rs = 8; t.rt = 3; t.exmr = 1; t.exrw = 1; t.exrd = 8;
        t.pc = 32'h0000_1000; t.imm = 32'h10;
        run_instr(t, "load_use");
        t = blank();
        t.beq = 1; t.zero = 1; t.rs = 0; t.exmr = 1; t.exrd = 0;
        run_instr(t, "load_use_r0");
        t = blank();
        t.bne = 1; t.zero = 1; t.rt = 5; t.memmr = 1; t.memrd = 5; t.pc = 32'h2000;
        run_instr(t, "mem_load");
    endtask

    task automatic test_jump_priority();
        instr_t t = blank();
        t.j = 1; t.beq = 1; t.zero = 1; t.pc = 32'hA000_0004; t.idx = 26'h000_0100;
        t.rs = 7; t.exmr = 1; t.exrd = 7;
        run_instr(t, "jump_beq");
        total++;
        if (branchTargetOutput !== 32'hA000_0400)
            $display("FAIL jump_beq_const: target=%h, want a0000400", branchTargetOutput);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            instr_t t = blank();
            int kind = $urandom_range(0, 5);
            t.beq = (kind == 0 || kind == 4); t.bne = (kind == 1 || kind == 4);
            t.j = (kind == 2 || (kind == 4 && $urandom_range(0, 1) == 1));
            t.zero = 1'($urandom); t.pc = $urandom; t.imm = $urandom;
            t.idx = 26'($urandom);
            t.rs = 5'($urandom_range(0, 3)); t.rt = 5'($urandom_range(0, 3));
            t.exrd = 5'($urandom_range(0, 3)); t.memrd = 5'($urandom_range(0, 3));
            t.exrw = 1'($urandom); t.exmr = 1'($urandom); t.memmr = 1'($urandom);
            run_instr(t, "random");
        end
    endtask

    task automatic test_counter_wrap();
        instr_t t = blank();
        t.j = 1; t.pc = 32'h0; t.idx = 26'h40;
        while (exp_tc != (1 << CW) - 1) run_instr(t, "wrap_fill");
        total++;
        if (takenCountOutput !== {CW{1'b1}})
            $display("FAIL wrap_full: taken=%h, want all ones", takenCountOutput);
        else passed++;
        run_instr(t, "wrap_last");
        total++;
        if (takenCountOutput !== CW'(0))
            $display("FAIL wrap_zero: taken=%h, want 0", takenCountOutput);
        else passed++;
    endtask

    task automatic test_reset_mid_stall();
        instr_t t = blank();
        t.beq = 1; t.rs = 9; t.exmr = 1; t.exrd = 9;
        @(posedge clock); #1 apply(t);
        @(posedge clock); #1;
        total++;
        if (stallOutput !== 1'b1)
            $display("FAIL mid_stall_setup: stall=%b, want 1", stallOutput);
        else passed++;
        reset = 1; clear_inputs();
        @(posedge clock); #1 reset = 0;
        exp_bc = 0; exp_tc = 0; exp_tgt = 0;
        #1 check_all_zero("reset_mid_stall");
        @(posedge clock); #2 check_all_zero("reset_mid_stall_after");
    endtask

    task automatic test_reset_mid_redirect();
        instr_t t = blank();
        t.j = 1; t.pc = 32'h5000_0000; t.idx = 26'h3;
        @(posedge clock); #1 apply(t);
        @(posedge clock); #1 clear_inputs();
        total++;
        if (pcSrcOutput !== 1'b1)
            $display("FAIL mid_redirect_setup: pcSrc=%b, want 1", pcSrcOutput);
        else passed++;
        reset = 1;
        @(posedge clock); #1 reset = 0;
        exp_bc = 0; exp_tc = 0; exp_tgt = 0;
        #1 check_all_zero("reset_mid_redirect");
        // Reset coinciding with a taken resolution must not redirect.
        @(posedge clock); #1 apply(t); reset = 1;
        @(posedge clock); #1 reset = 0; clear_inputs();
        #1 check_all_zero("reset_at_resolve");
        @(posedge clock); #2 check_all_zero("reset_at_resolve_after");
    endtask

    initial begin
        test_reset();
        test_taken_beq();
        test_not_taken_bne();
        test_negative_offset();
        test_load_use();
        test_jump_priority();
        test_random();
        do_reset();
        test_counter_wrap();
        test_reset_mid_stall();
        test_reset_mid_redirect();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
